// File: rtl/vram_pkg.sv
// vram_pkg: shared VRAM geometry and rectangle-fill state encoding
package vram_pkg;
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int VRAM_ADDR_W = 19;
    localparam int VRAM_COLOR_W = 12;
    typedef enum logic [1:0] {IDLE, SETUP, FILL, DONE} fill_state_t;
endpackage

// File: rtl/rect_clip.sv
// rect_clip: clips a rectangle to the screen and computes its first VRAM address
module rect_clip
    import vram_pkg::*;
#(
    parameter int WIDTH = SCREEN_W,
    parameter int HEIGHT = SCREEN_H,
    parameter int ADDR_W = VRAM_ADDR_W
) (
    input  logic [9:0]        x,
    input  logic [8:0]        y,
    input  logic [9:0]        w,
    input  logic [8:0]        h,
    output logic [9:0]        ew,
    output logic [8:0]        eh,
    output logic              empty,
    output logic [ADDR_W-1:0] start_addr
);
    logic [10:0] end_x;
    logic [9:0]  end_y;
    always_comb begin
        end_x = {1'b0, x} + {1'b0, w};
        end_y = {1'b0, y} + {1'b0, h};
        empty = (x >= 10'(WIDTH)) || (y >= 9'(HEIGHT)) || (w == '0) || (h == '0);
        ew = (end_x > 11'(WIDTH)) ? 10'(11'(WIDTH) - {1'b0, x}) : w;
        eh = (end_y > 10'(HEIGHT)) ? 9'(10'(HEIGHT) - {1'b0, y}) : h;
        start_addr = ADDR_W'(y) * ADDR_W'(WIDTH) + ADDR_W'(x);
    end
endmodule

// File: rtl/vram_rect_fill.sv
// vram_rect_fill: clips a rectangle command and streams one VRAM pixel write per clock in raster order
module vram_rect_fill
    import vram_pkg::*;
#(
    parameter int WIDTH = SCREEN_W,
    parameter int HEIGHT = SCREEN_H,
    parameter int ADDR_W = VRAM_ADDR_W,
    parameter int COLOR_W = VRAM_COLOR_W
) (
    input  logic               vram_clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [9:0]         cmd_x,
    input  logic [8:0]         cmd_y,
    input  logic [9:0]         cmd_w,
    input  logic [8:0]         cmd_h,
    input  logic [COLOR_W-1:0] cmd_color,
    output logic               busy,
    output logic               done,
    output logic               we,
    output logic [ADDR_W-1:0]  addr,
    output logic [COLOR_W-1:0] data
);
    fill_state_t state, state_nxt;
    logic [9:0] x_q, w_q, ew, ew_q, col;
    logic [8:0] y_q, h_q, eh, eh_q, row;
    logic [COLOR_W-1:0] color_q;
    logic [ADDR_W-1:0] start_addr, row_base;
    logic empty, row_end, last;

    rect_clip #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .ADDR_W(ADDR_W)) u_clip (
        .x(x_q), .y(y_q), .w(w_q), .h(h_q),
        .ew(ew), .eh(eh), .empty(empty), .start_addr(start_addr)
    );

    assign row_end = col == ew_q - 10'd1;
    assign last = row_end && (row == eh_q - 9'd1);

    always_ff @(posedge vram_clk) state <= rst ? IDLE : state_nxt;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = cmd_valid ? SETUP : IDLE;
            SETUP:   state_nxt = empty ? DONE : FILL;
            FILL:    state_nxt = last ? DONE : FILL;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (state == IDLE) && !rst;
        busy = state != IDLE;
        done = state == DONE;
    end

    always_ff @(posedge vram_clk) begin
        if (cmd_ready && cmd_valid) begin
            x_q <= cmd_x;
            y_q <= cmd_y;
            w_q <= cmd_w;
            h_q <= cmd_h;
            color_q <= cmd_color;
        end
        if (state == SETUP) begin
            ew_q <= ew;
            eh_q <= eh;
            col <= '0;
            row <= '0;
            row_base <= start_addr;
        end else if (state == FILL) begin
            col <= row_end ? '0 : col + 10'd1;
            row <= row_end ? row + 9'd1 : row;
            row_base <= row_end ? row_base + ADDR_W'(WIDTH) : row_base;
        end
    end

    // Write port runs one pixel ahead of the counters so the first write lands the cycle after SETUP
    always_ff @(posedge vram_clk) begin
        if (rst) begin
            we <= 1'b0;
            addr <= '0;
            data <= '0;
        end else if (state == SETUP) begin
            we <= !empty;
            addr <= empty ? addr : start_addr;
            data <= empty ? data : color_q;
        end else if (state == FILL) begin
            we <= !last;
            addr <= last ? addr : (row_end ? row_base + ADDR_W'(WIDTH) : addr + 1'b1);
        end else begin
            we <= 1'b0;
        end
    end
endmodule

// File: doc/vram_rect_fill.md
# vram_rect_fill

Command-driven rectangle fill engine that writes solid-colour rectangles into the 640x480, 12-bit-per-pixel VRAM through its write port (we/addr/data). It sits directly upstream of the VGA output block, between game/render logic and the VRAM write port. It accepts one rectangle command per valid/ready handshake, clips the rectangle to the screen, and streams one pixel write per clock in raster order. A full-screen command is the screen-clear path.

## Interface
- WIDTH, 640, screen width in pixels; also the VRAM row pitch
- HEIGHT, 480, screen height in pixels
- ADDR_W, 19, VRAM address width
- COLOR_W, 12, pixel width (4:4:4 RGB)

- vram_clk  in  1  single clock, same clock as the VRAM write port
- rst  in  1  reset; synchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  engine can accept a command
- cmd_x  in  10  left column
- cmd_y  in  9  top row
- cmd_w  in  10  width in pixels
- cmd_h  in  9  height in pixels
- cmd_color  in  COLOR_W  fill colour
- busy  out  1  command in progress (SETUP, FILL or DONE)
- done  out  1  one-cycle pulse when a command completes
- we  out  1  VRAM write enable
- addr  out  ADDR_W  VRAM write address, row*WIDTH+col
- data  out  COLOR_W  VRAM write data

## Operation
- States: IDLE, SETUP, FILL, DONE.
- IDLE: cmd_ready=1. On cmd_valid&cmd_ready, latch all cmd_* fields and go to SETUP. Fields are ignored at any other time.
- SETUP (1 cycle):
  - Clip: if x>=WIDTH or y>=HEIGHT, w==0 or h==0, the rectangle is empty.
  - Otherwise ew=min(w, WIDTH-x) and eh=min(h, HEIGHT-y). Compute the sums at 11/10 bits so they cannot overflow.
  - Compute start address y*WIDTH+x; the one multiply is allowed here only.
  - Empty goes to DONE; otherwise go to FILL.
- FILL:
  - Emit one write per cycle: col 0..ew-1 within a row, rows 0..eh-1.
  - Addresses are generated incrementally: +1 within a row; row_base+=WIDTH at the start of each new row. No multiplier in the loop.
  - After the write of the last pixel, go to DONE.
- DONE (1 cycle): done=1, then IDLE.
- we/addr/data are registered. When we=0, addr and data hold their last values.
- Reset values: cmd_ready=0 during rst, then 1 the cycle after rst drops. busy=0, done=0, we=0, addr=0, data=0, state=IDLE.
- rst mid-command: the in-flight command is aborted and the remaining pixels are never written. we=0 from the cycle after rst is sampled, and done is not pulsed.
- There is no write-back-pressure input; the VRAM port accepts one write per cycle unconditionally.

## Timing
- Handshake occurs in cycle 0; SETUP is cycle 1.
- Writes occur in cycles 2..N+1, where N=ew*eh. done=1 in cycle N+2, and cmd_ready=1 again in cycle N+3.
- Empty rectangle: done in cycle 2, no writes, cmd_ready in cycle 3.
- Throughput: N+3 cycles per command. With cmd_valid held high, back-to-back commands are accepted every N+3 cycles.
- busy is the inverse of cmd_ready outside reset.
- Full-screen clear (N=307200): the last write is at addr 307199 in cycle 307201, and done is in cycle 307202.

## Structure
- Shared package vram_pkg holds:
  - SCREEN_W=640, SCREEN_H=480, VRAM_ADDR_W=19, VRAM_COLOR_W=12.
  - The state enum for this block.
- Sub-module rect_clip: combinational. Takes x, y, w, h and outputs ew, eh, empty and start_addr. It is instantiated once and used only in SETUP; a registered output is allowed if SETUP grows to 2 cycles, in which case all latencies shift by 1.

## Test plan
- Basic rectangle: x=10, y=2, w=3, h=2, color=0xF00.
  - Writes in cycles 2..7 at addrs 1290, 1291, 1292, 1930, 1931, 1932, all with data 0xF00.
  - done in cycle 8; cmd_ready in cycle 9.
- Clipping: x=638, y=479, w=5, h=5.
  - Exactly 2 writes, at 307198 and 307199.
  - done in cycle 4; no address >=307200 ever appears.
- Empty and off-screen commands: w=0; then x=640; then y=480.
  - For each: no we, done in cycle 2.
- Full clear: x=0, y=0, w=640, h=480, color=0x000.
  - 307200 consecutive writes with addresses 0..307199 contiguous; done in cycle 307202.
- Reset abort: rst asserted in cycle 5 of a 640x2 fill.
  - we=0 from cycle 6, no done pulse.
  - cmd_ready=1 on the cycle after rst deasserts; a new command then completes normally.
- Back-to-back: cmd_valid held high with two 2x1 commands.
  - Second handshake in cycle 5; its writes are in cycles 7-8.
  - cmd_* changes while busy have no effect.
